// File: rtl/fifo_defines_pkg.sv
// Shared widths, run-length default and reader FSM encoding for the waveform sample FIFO path.
package fifo_defines_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int NUM_SAMPLES_DEF = 256;

  typedef logic [2:0] reader_state_t;

  localparam reader_state_t ST_IDLE = 3'd0;
  localparam reader_state_t ST_REQ  = 3'd1;
  localparam reader_state_t ST_CAPT = 3'd2;
  localparam reader_state_t ST_HOLD = 3'd3;
  localparam reader_state_t ST_DONE = 3'd4;

endpackage

// File: rtl/wave_fifo_reader_peak_tracker.sv
// Signed running max/min of captured samples; the first load after clr_i seeds both registers.
module peak_tracker #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] peak_o,
  output logic [DATA_WIDTH-1:0] trough_o
);

  logic first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b0;
      peak_o   <= '0;
      trough_o <= '0;
    end else if (clr_i) begin
      first <= 1'b1;
    end else if (load_i) begin
      first <= 1'b0;
      if (first || ($signed(sample_i) > $signed(peak_o)))
        peak_o <= sample_i;
      if (first || ($signed(sample_i) < $signed(trough_o)))
        trough_o <= sample_i;
    end
  end

endmodule

// File: rtl/wave_fifo_reader.sv
// Pops one FIFO word at a time into a held valid/ready output register and tracks per-run stats.
module wave_fifo_reader #(
  parameter int DATA_WIDTH  = fifo_defines_pkg::DATA_WIDTH,
  parameter int NUM_SAMPLES = fifo_defines_pkg::NUM_SAMPLES_DEF,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic [DATA_WIDTH-1:0] peak_o,
  output logic [DATA_WIDTH-1:0] trough_o,
  output logic [CNT_W-1:0]      sample_cnt_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import fifo_defines_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SAMPLES);

  reader_state_t    state, state_nxt;
  logic             start_ok;
  logic             capture;
  logic             handshake;
  logic [CNT_W-1:0] cnt_inc;

  assign start_ok  = start_i && !stop_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign capture   = (state == ST_CAPT) && !stop_i;
  assign handshake = (state == ST_HOLD) && sample_ready_i && !stop_i;
  assign cnt_inc   = (sample_cnt_o == CNT_MAX) ? sample_cnt_o : sample_cnt_o + CNT_W'(1);

  // Only one word in flight: the pop is issued from REQ and consumed in CAPT.
  assign fifo_rd_en_o = (state == ST_REQ) && !fifo_empty_i && !stop_i;

  assign busy_o = (state == ST_REQ) || (state == ST_CAPT) || (state == ST_HOLD);
  assign done_o = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    if (stop_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_i) state_nxt = ST_REQ;
        ST_REQ:           if (!fifo_empty_i) state_nxt = ST_CAPT;
        ST_CAPT:          state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (sample_ready_i)
            state_nxt = (cnt_inc == CNT_MAX) ? ST_DONE : ST_REQ;
        end
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sample_cnt_o   <= '0;
    end else begin
      state <= state_nxt;

      if (start_ok)
        sample_cnt_o <= '0;
      else if (handshake)
        sample_cnt_o <= cnt_inc;

      if (capture)
        sample_o <= fifo_rd_data_i;

      if (stop_i || handshake)
        sample_valid_o <= 1'b0;
      else if (capture)
        sample_valid_o <= 1'b1;
    end
  end

  peak_tracker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_peak_tracker (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start_ok),
    .load_i   (capture),
    .sample_i (fifo_rd_data_i),
    .peak_o   (peak_o),
    .trough_o (trough_o)
  );

endmodule

// File: tb/tb_wave_fifo_reader.sv
// Scoreboard bench for wave_fifo_reader with a behavioural FIFO and a decoupled output monitor.
module tb_wave_fifo_reader;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, stop_i;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] peak, trough;
  logic [CW-1:0] cnt;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  int            exp_q[$];
  int            n_push = 0;
  int            n_pop  = 0;

  always #5 clk = ~clk;

  wave_fifo_reader #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .peak_o         (peak),
    .trough_o       (trough),
    .sample_cnt_o   (cnt),
    .busy_o         (busy),
    .done_o         (done)
  );

  // Behavioural FIFO: read data appears the cycle after the pop.
  assign fifo_empty = (n_push == n_pop);
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_rd_data <= fq.pop_front();
      n_pop <= n_pop + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on each handshake, plus protocol invariants.
  logic          prev_hold = 1'b0;
  logic          prev_rd   = 1'b0;
  logic [DW-1:0] prev_sample = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      prev_rd   = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty || prev_rd) begin
          errors++;
          $display("FAIL rd_en_protocol: empty=%0b prev_rd=%0b", fifo_empty, prev_rd);
        end
      end
      if (prev_hold) begin
        checks++;
        if (!sample_valid || sample !== prev_sample) begin
          errors++;
          $display("FAIL valid_stable: valid=%0b sample=%0d, expected valid=1 sample=%0d",
                   sample_valid, $signed(sample), $signed(prev_sample));
        end
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0d, expected none", $signed(sample));
        end else begin
          chk("stream_sample", int'($signed(sample)), exp_q.pop_front());
        end
      end
      prev_hold   = sample_valid && !sample_ready;
      prev_sample = sample;
      prev_rd     = fifo_rd_en;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input bit expect_out);
    fq.push_back(DW'(v));
    n_push = n_push + 1;
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, int'(done), 1);
  endtask

  task automatic wait_rd(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fifo_rd_en) break;
    end
    chk(nm, int'(fifo_rd_en), 1);
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sample_valid) break;
    end
    chk(nm, int'(sample_valid), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample"}, int'(sample), 0);
    chk({tag, "_valid"},  int'(sample_valid), 0);
    chk({tag, "_peak"},   int'(peak), 0);
    chk({tag, "_trough"}, int'(trough), 0);
    chk({tag, "_cnt"},    int'(cnt), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_done"},   int'(done), 0);
    chk({tag, "_rd_en"},  int'(fifo_rd_en), 0);
  endtask

  initial begin
    int viol;
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; sample_ready = 1'b0;
    cyc(2);
    @(negedge clk);
    chk_all_zero("reset");
    cyc(1);
    rst = 1'b0;

    // T2: basic run
    push(5, 1); push(-3, 1); push(12, 1); push(0, 1);
    sample_ready = 1'b1;
    pulse_start();
    wait_done("t2_done");
    chk("t2_peak",   int'($signed(peak)), 12);
    chk("t2_trough", int'($signed(trough)), -3);
    chk("t2_cnt",    int'(cnt), 4);
    chk("t2_busy",   int'(busy), 0);
    chk("t2_drained", exp_q.size(), 0);

    // T3: underflow, then single word
    cyc(1);
    pulse_start();
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_rd_en || sample_valid) viol++;
    end
    chk("t3_underflow_quiet", viol, 0);
    chk("t3_busy", int'(busy), 1);
    cyc(1);
    push(7, 1);
    wait_rd("t3_rd");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t3_valid_lat2", int'(sample_valid), 1);
    chk("t3_sample", int'($signed(sample)), 7);

    // T4: backpressure
    cyc(1);
    sample_ready = 1'b0;
    push(100, 1);
    wait_valid("t4_valid");
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (!sample_valid || $signed(sample) != 100 || fifo_rd_en || cnt != 1) viol++;
    end
    chk("t4_hold_stable", viol, 0);
    cyc(1);
    sample_ready = 1'b1;
    push(-50, 1); push(9, 1);
    wait_done("t4_done");
    chk("t4_peak",   int'($signed(peak)), 100);
    chk("t4_trough", int'($signed(trough)), -50);
    chk("t4_cnt",    int'(cnt), 4);

    // T5: abort in the cycle after the pop
    cyc(1);
    push(33, 0);
    pulse_start();
    wait_rd("t5_rd");
    @(posedge clk);
    #1;
    stop_i = 1'b1;
    cyc(1);
    stop_i = 1'b0;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid) viol++;
    end
    chk("t5_no_valid", viol, 0);
    chk("t5_busy",   int'(busy), 0);
    chk("t5_done",   int'(done), 0);
    chk("t5_peak",   int'($signed(peak)), 100);
    chk("t5_trough", int'($signed(trough)), -50);
    chk("t5_cnt",    int'(cnt), 0);

    // T6: signed extremes
    cyc(1);
    push(32767, 1); push(-32768, 1); push(1, 1); push(2, 1);
    pulse_start();
    wait_done("t6_done");
    chk("t6_peak",   int'($signed(peak)), 32767);
    chk("t6_trough", int'($signed(trough)), -32768);
    chk("t6_cnt",    int'(cnt), 4);

    // T1: async reset mid-HOLD
    cyc(1);
    sample_ready = 1'b0;
    push(11, 0);
    pulse_start();
    wait_valid("t1_valid");
    cyc(1);
    rst = 1'b1;
    #1;
    chk_all_zero("t1_rst");
    cyc(1);
    rst = 1'b0;
    sample_ready = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("t1_idle_busy",  int'(busy), 0);
    chk("t1_idle_done",  int'(done), 0);
    chk("t1_idle_valid", int'(sample_valid), 0);
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
